// File: rtl/mips_regfile_scoreboard.sv
// mips_regfile_scoreboard: multi-port MIPS register file with write bypass and pending-load scoreboard.
module mips_regfile_scoreboard #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int NUM_READ    = 2,
    parameter int BYPASS      = 1,
    parameter int DEBUG_INDEX = 2,
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_READ*IDX_W-1:0]      rd_index,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_pending,
    output logic                           stall,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic                           wb_enable,
    input  logic [IDX_W-1:0]               wb_index,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           ld_enable,
    input  logic [IDX_W-1:0]               ld_index,
    input  logic [DATA_WIDTH-1:0]          ld_data,
    input  logic                           issue_load,
    input  logic [IDX_W-1:0]               issue_index,
    output logic [IDX_W:0]                 pending_count,
    output logic [DATA_WIDTH-1:0]          debug_data
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pend;
    logic                  wb_v, ld_v, iss_v, inc, dec;

    // Gating with reset keeps bypass paths quiet while reset is held low.
    assign wb_v  = reset && wb_enable  && wb_index    != '0;
    assign ld_v  = reset && ld_enable  && ld_index    != '0;
    assign iss_v = reset && issue_load && issue_index != '0;
    assign inc   = iss_v && !pend[issue_index];
    assign dec   = ld_v && pend[ld_index] && !(iss_v && issue_index == ld_index);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pend          <= '0;
            pending_count <= '0;
        end else begin
            if (wb_v) regs[wb_index] <= wb_data;
            if (ld_v) regs[ld_index] <= ld_data;
            if (ld_v) pend[ld_index] <= 1'b0;
            if (iss_v) pend[issue_index] <= 1'b1;
            pending_count <= pending_count + (IDX_W+1)'(inc) - (IDX_W+1)'(dec);
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [IDX_W-1:0] idx;
        logic             ld_hit, wb_hit;
        assign idx    = rd_index[p*IDX_W +: IDX_W];
        assign ld_hit = BYPASS != 0 && ld_v && ld_index == idx;
        assign wb_hit = BYPASS != 0 && wb_v && wb_index == idx;
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = ld_hit ? ld_data : wb_hit ? wb_data : regs[idx];
        assign rd_pending[p] = pend[idx] && !ld_hit;
    end

    assign stall      = |(rd_pending & rd_en);
    assign debug_data = regs[IDX_W'(DEBUG_INDEX)];
endmodule

// File: doc/mips_regfile_scoreboard.md
# mips_regfile_scoreboard

Parametrised MIPS general-purpose register file for the pipelined core. It provides NUM_READ combinational read ports and two write ports: ALU writeback and late load return. Optional same-cycle write-to-read bypass is supported. A per-register pending-load scoreboard drives a stall request to decode. It sits between IR decode (read/issue side) and the writeback/memory stages (write side), and exposes one debug register, $v0 by default, to the top level.

## Interface
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 32, register count; power of two, ≥ 2. IDX_W = $clog2(NUM_REGS).
- NUM_READ, 2, number of read ports, 1..4.
- BYPASS, 1: same-cycle write data is forwarded to reads. 0: reads return stored value only.
- DEBUG_INDEX, 2, register mirrored on debug_data.
- clk  in  1  single clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- rd_index  in  NUM_READ*IDX_W  packed read indices; port p at [p*IDX_W +: IDX_W].
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data.
- rd_pending  out  NUM_READ  port p's register has an outstanding load.
- stall  out  1  OR of rd_pending over ports whose rd_en bit is set.
- rd_en  in  NUM_READ  port p is actually used by the instruction in decode.
- wb_enable  in  1  ALU writeback strobe.
- wb_index  in  IDX_W  ALU writeback destination.
- wb_data  in  DATA_WIDTH  ALU writeback value.
- ld_enable  in  1  load-return strobe.
- ld_index  in  IDX_W  load destination.
- ld_data  in  DATA_WIDTH  load value.
- issue_load  in  1  decode issues a load; marks issue_index pending.
- issue_index  in  IDX_W  load destination being issued.
- pending_count  out  IDX_W+1  number of registers currently pending.
- debug_data  out  DATA_WIDTH  current stored value of register DEBUG_INDEX, no bypass.

## Operation
- Register 0 reads 0 always. Writes and issues to index 0 are ignored and never set pending.
- Write resolution per edge, when reset is high:
  - wb_enable writes wb_data to wb_index.
  - ld_enable writes ld_data to ld_index.
  - Both target the same index: ld_data wins.
- Read p, combinational:
  - If BYPASS=1 and a write enable targets rd_index[p] (≠0), return that write's data, applying the same ld-over-wb priority.
  - Otherwise return the stored value.
- Scoreboard, one pending bit per register:
  - issue_load with issue_index≠0 sets the bit.
  - ld_enable clears the bit at ld_index.
  - Same edge, same index, issue and ld: the bit stays set (a new load supersedes the returning one); the data is still written.
  - wb_enable does not affect pending bits. A wb write to a pending register is legal; the later ld return overwrites it.
  - Issue to an already-pending register: the bit stays set; the count is unchanged.
  - ld_enable to a non-pending register: a plain write; the count is unchanged.
- pending_count equals the population count of the pending bits, maintained incrementally: +1 on set of a clear bit, −1 on clear of a set bit, net 0 when both happen on different registers in the same edge.
- rd_pending[p] reflects registered pending bits. With BYPASS=1, a same-cycle ld_enable to rd_index[p] masks rd_pending[p] to 0, because the forwarded data is valid.
- Reset low: all registers 0, all pending bits 0, pending_count 0. Write, issue and bypass inputs are ignored while reset is low, so rd_data, rd_pending, stall and debug_data all read 0.

## Timing
- Reads, rd_pending and stall: zero-latency combinational from rd_index/rd_en and the write ports.
- Writes are visible in stored state after the rising edge: 1-cycle latency when BYPASS=0, 0 cycles when BYPASS=1.
- Pending bits and pending_count update on the rising edge following the issue or load return.
- Reset assertion is asynchronous and takes effect mid-cycle. Deassertion is sampled by clk; the first write is accepted on the first rising edge with reset high.
- No handshake back-pressure on write ports: every enabled write is accepted on its edge.

## Test plan
- Reset sweep: write 0xDEADBEEF to r5, pull reset low mid-cycle → rd_data for r5 is 0 immediately, pending_count 0, debug_data 0.
- Bypass: BYPASS=1, wb r7=0x12345678 while reading r7 → rd_data 0x12345678 in the same cycle. Repeat with BYPASS=0 → old value that cycle, new value next cycle.
- Write conflict: wb r3=0x1 and ld r3=0x2 on the same edge → r3 reads 0x2. Writes of 0xFFFFFFFF to r0 → r0 still reads 0.
- Scoreboard: issue r8 → next cycle rd_pending=1, stall=1 with rd_en set, pending_count 1. ld r8=0xAA → same cycle rd_pending masked (BYPASS=1), next cycle pending 0, count 0.
- Simultaneous issue and return: r9 pending; issue r9 and ld r9=0x55 on the same edge → r9 reads 0x55, pending stays 1, count stays 1. Issue r10 + ld r9 on the same edge → count unchanged at 1.
- Parameter sweep: NUM_REGS=16, NUM_READ=3, DATA_WIDTH=64 → all three ports read independent registers correctly, and pending_count reaches 15 with r1..r15 issued.
